// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the riscv pipeline (IF/MEM stages), the memory arbiter
// and the unified single-ported memory. The arbiter connects through the
// slave modport; the pipeline/memory environment uses the master modport.
interface riscv_mem_arbiter_if;
  // fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  // data port
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  // memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  // pipeline control and status
  logic        stall_if;
  logic        stall_mem;
  logic        err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           stall_if, stall_mem, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           stall_if, stall_mem, err
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the
// data stage. Data normally wins a tie; fetch is forced through after
// STARVE_LIMIT consecutive data grants. Each transaction walks
// IDLE -> BUSY_* -> DONE, so the served requester is never re-granted on its
// stale request. A transaction without mem_ready for TIMEOUT cycles is
// aborted with a substitute response and a sticky error flag.
module riscv_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input logic                 clk,
  input logic                 reset,
  riscv_mem_arbiter_if.slave  bus
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);
  localparam logic [31:0]   NOP_INSN   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;

  state_e        state_q,      state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [TW-1:0] tmo_cnt_q,    tmo_cnt_d;
  logic [TW-1:0] tmo_next;
  logic          mem_req_q,    mem_req_d;
  logic          mem_we_q,     mem_we_d;
  logic [31:0]   mem_addr_q,   mem_addr_d;
  logic [31:0]   mem_wdata_q,  mem_wdata_d;
  logic [3:0]    mem_be_q,     mem_be_d;
  logic [31:0]   if_rdata_q,   if_rdata_d;
  logic [31:0]   dm_rdata_q,   dm_rdata_d;
  logic          if_ack_q,     if_ack_d;
  logic          dm_ack_q,     dm_ack_d;
  logic          err_q,        err_d;

  // Next-state, grant decision and response capture.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can leave it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    tmo_next     = tmo_cnt_q + 1'b1;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (!bus.if_req) starve_cnt_d = '0;
        // Data wins ties unless fetch has already been passed over too often.
        if (bus.dm_req && !(bus.if_req && starve_cnt_q == STARVE_MAX)) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          mem_be_d    = bus.dm_be;
          tmo_cnt_d   = '0;
          state_d     = BUSY_D;
          // Only reachable below the limit when fetch waits, so this saturates.
          if (bus.if_req) starve_cnt_d = starve_cnt_q + 1'b1;
        end else if (bus.if_req) begin
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
          mem_be_d     = 4'hF;
          tmo_cnt_d    = '0;
          starve_cnt_d = '0;
          state_d      = BUSY_I;
        end
      end

      BUSY_I, BUSY_D: begin
        tmo_cnt_d = tmo_next;
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (state_q == BUSY_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
          end
        end else if (tmo_next == TMO_MAX) begin
          // Abort: the pipeline still gets an ack so it never hangs.
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
          if (state_q == BUSY_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = NOP_INSN;
          end else begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = '0;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // values, independent of statement order.
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      err_q        <= err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.err       = err_q;

  // Pipeline freezes while its request is outstanding.
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = bus.dm_req & ~dm_ack_q;

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch (IF) and data-memory (MEM) stages of the riscv core.
- Arbitrates requests, sequences the multi-cycle memory handshake and returns read data plus a one-cycle ack to the winner.
- Derives the IF and MEM stall signals the pipeline uses to freeze.
- Includes starvation protection for fetch and a sticky timeout error flag.

Parameters:
- STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending before fetch is forced to win.
- TIMEOUT, 15, cycles spent in a BUSY state without mem_ready before the transaction is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  registered fetched instruction.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held high with all dm_* inputs stable until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_be  in  4  store byte enables.
- dm_rdata  out  32  registered load data.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  32  memory read data, valid when mem_ready = 1.
- mem_ready  in  1  memory completion, sampled only while mem_req = 1.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_mem  out  1  dm_req & ~dm_ack (combinational).
- err  out  1  sticky timeout flag.

Behaviour:

Reset:
- reset low asynchronously forces state = IDLE.
- All registered outputs go to 0: if_rdata, dm_rdata, acks, mem_*, err.
- Starvation counter and timeout counter go to 0.
- mem_req drops immediately, even mid-transaction; the pending transaction is discarded and no ack is issued.

FSM states: IDLE, BUSY_I, BUSY_D, DONE.

IDLE:
- Neither request high: stay in IDLE.
- Only one request high: grant that requester.
- Both requests high: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- Grant to data: latch dm_* onto mem_*, set mem_req = 1, go to BUSY_D.
- Grant to fetch: mem_addr = if_addr, mem_we = 0, mem_be = 4'hF, mem_wdata = 0, mem_req = 1, go to BUSY_I.

BUSY_I / BUSY_D:
- mem_* outputs are held constant.
- The timeout counter increments every cycle.
- mem_ready = 1: drop mem_req, go to DONE, and pulse the winner's ack during DONE.
  - Fetch: if_rdata <= mem_rdata.
  - Load: dm_rdata <= mem_rdata.
  - Store: dm_rdata is unchanged.
- Counter reaches TIMEOUT with no mem_ready: drop mem_req, set err = 1, go to DONE.
  - ack still pulses.
  - rdata is set to 32'h0000_0013 (NOP) for fetch, 0 for a load.

DONE:
- The selected ack is high for exactly this cycle.
- Always returns to IDLE, so the still-high req of the just-served requester is never re-granted.
- The requester must drop or refresh req on the edge after ack.

Latency and throughput:
- req sampled at edge N gives mem_req high from N+1.
- mem_ready at edge N+1+k gives ack high in the cycle after that edge.
- Minimum 3 cycles from req to ack.
- Maximum throughput is 1 transaction per 3 cycles.

Starvation counter:
- Increments on each data grant made while if_req = 1, saturating at STARVE_LIMIT.
- Clears on any fetch grant, or in IDLE when if_req = 0.

Other rules:
- err is cleared only by reset.
- mem_ready is ignored in IDLE and DONE.
- The timeout counter clears on entry to BUSY_*.

Test Plan:
1. Reset, then if_req = 1 with if_addr = 0x100; memory answers mem_ready on the first BUSY cycle with 0x00500093 -> mem_addr = 0x100, mem_we = 0, mem_be = F; if_ack pulses one cycle with if_rdata = 0x00500093, 3 cycles after req; stall_if high until the ack.
2. if_req and dm_req rise together (load from 0x2000, memory returns 0xDEADBEEF) -> data is granted first with dm_ack and dm_rdata = 0xDEADBEEF; fetch is granted in the following IDLE.
3. Store with dm_addr = 0x2004, dm_wdata = 0x12345678, dm_be = 4'b0011 -> mem_we = 1 and mem_be = 0011 held through a 3-cycle mem_ready delay; dm_ack pulses and dm_rdata is unchanged.
4. if_req held high while dm_req is re-asserted back-to-back -> exactly 4 data grants, then a fetch grant, then data resumes.
5. mem_ready never asserted on a fetch -> after 15 BUSY cycles mem_req drops, if_ack pulses with if_rdata = 0x00000013, and err stays 1 through later successful transactions.
6. reset pulled low during BUSY_D -> mem_req, acks and err are 0 immediately and no dm_ack is issued; after release, a fresh request completes normally.
